// File: rtl/nn_link_pkg.sv
// Shared constants and FSM state type for the Arduino serial link (both directions).
package nn_link_pkg;

  localparam int unsigned dataWidth  = 16;
  localparam int unsigned numOutputs = 10;
  localparam int unsigned frameWords = numOutputs + 1;
  localparam logic [7:0]  headerTag  = 8'hA5;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} nn_state_e;

endpackage

// File: rtl/nn_result_serializer_if.sv
// Result-offer and serial-pin bundle between the network side and the serializer.
interface nn_result_serializer_if;
  import nn_link_pkg::*;

  logic [numOutputs*dataWidth-1:0] NNout;
  logic [3:0]                      maxIndex;
  logic                            resultValid;
  logic                            ready;
  logic                            serialClockOut;
  logic                            serialDataOut;
  logic                            frameOut;
  logic                            txDone;
  logic                            overrun;

  modport master (
    output NNout, maxIndex, resultValid,
    input  ready, serialClockOut, serialDataOut, frameOut, txDone, overrun
  );

  modport slave (
    input  NNout, maxIndex, resultValid,
    output ready, serialClockOut, serialDataOut, frameOut, txDone, overrun
  );

endinterface

// File: rtl/serial_tick_gen.sv
// Half-period divider for the serial clock; held cleared while disabled.
module serial_tick_gen #(
  parameter int unsigned clkDiv = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic phase_en_i,
  output logic half_tick_o,
  output logic phase_o
);

  localparam int unsigned CntW = $clog2(clkDiv);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  assign half_tick_o = en_i && (cnt_q == CntW'(clkDiv - 1));
  assign phase_o     = phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (half_tick_o) begin
      cnt_d = '0;
      // Phase only toggles while bits are shifting; lead/trail keep the clock low.
      if (phase_en_i) phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/nn_result_serializer.sv
// Captures a classification result and sends it as one framed MSB-first burst of words.
module nn_result_serializer
  import nn_link_pkg::*;
#(
  parameter int unsigned clkDiv = 25
) (
  input logic                   clk,
  input logic                   reset,
  nn_result_serializer_if.slave bus
);

  localparam int unsigned BitW  = $clog2(dataWidth);
  localparam int unsigned WordW = $clog2(frameWords);

  nn_state_e             state_q, state_d;
  logic [dataWidth-1:0]  frame_q [frameWords];
  logic [dataWidth-1:0]  frame_d [frameWords];
  logic [WordW-1:0]      word_q, word_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  sdo_q, sdo_d;
  logic                  ready_q, frame_out_q, tx_done_q;
  logic                  overrun_q, overrun_d;
  logic                  half_tick, phase;
  logic                  tick_en;

  assign tick_en = (state_q == LEAD) || (state_q == SHIFT) || (state_q == TRAIL);

  serial_tick_gen #(
    .clkDiv (clkDiv)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .en_i        (tick_en),
    .phase_en_i  (state_q == SHIFT),
    .half_tick_o (half_tick),
    .phase_o     (phase)
  );

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    word_d    = word_q;
    bit_d     = bit_q;
    sdo_d     = sdo_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (bus.resultValid) begin
          frame_d[0] = {headerTag, 4'h0, bus.maxIndex};
          for (int i = 0; i < numOutputs; i++) begin
            frame_d[i+1] = bus.NNout[i*dataWidth +: dataWidth];
          end
          word_d    = '0;
          bit_d     = BitW'(dataWidth - 1);
          sdo_d     = frame_d[0][dataWidth-1];
          overrun_d = 1'b0;
          state_d   = LEAD;
        end
      end
      LEAD: if (half_tick) state_d = SHIFT;
      SHIFT: begin
        // End of a high half: move data on the falling edge of the serial clock.
        if (half_tick && phase) begin
          if (bit_q == '0) begin
            if (word_q == WordW'(numOutputs)) begin
              sdo_d   = 1'b0;
              state_d = TRAIL;
            end else begin
              word_d = word_q + WordW'(1);
              bit_d  = BitW'(dataWidth - 1);
              sdo_d  = frame_q[word_q + WordW'(1)][dataWidth-1];
            end
          end else begin
            bit_d = bit_q - BitW'(1);
            sdo_d = frame_q[word_q][bit_q - BitW'(1)];
          end
        end
      end
      TRAIL: if (half_tick) state_d = DONE;
      DONE: begin
        sdo_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.resultValid && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < frameWords; i++) frame_q[i] <= '0;
      word_q      <= '0;
      bit_q       <= '0;
      sdo_q       <= 1'b0;
      ready_q     <= 1'b1;
      frame_out_q <= 1'b0;
      tx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      sdo_q       <= sdo_d;
      ready_q     <= (state_d == IDLE);
      frame_out_q <= (state_d == LEAD) || (state_d == SHIFT) || (state_d == TRAIL);
      tx_done_q   <= (state_d == DONE);
      overrun_q   <= overrun_d;
    end
  end

  assign bus.ready          = ready_q;
  assign bus.serialClockOut = phase;
  assign bus.serialDataOut  = sdo_q;
  assign bus.frameOut       = frame_out_q;
  assign bus.txDone         = tx_done_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_nn_result_serializer.sv
// Scoreboard bench: expected words queued at accept, reassembled from rising serial edges.
module tb_nn_result_serializer;
  import nn_link_pkg::*;

  localparam int unsigned ClkDiv      = 2;
  localparam int unsigned FrameBits   = 176;
  localparam int unsigned FrameCycles = ClkDiv * (2 + 2 * FrameBits);

  logic clk = 1'b0;
  logic reset;

  nn_result_serializer_if bus ();

  nn_result_serializer #(
    .clkDiv (ClkDiv)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  // Monitor: reassemble words from rising serial-clock edges, check frame totals on txDone.
  logic        sclk_prev   = 1'b0;
  int          edges_total = 0;
  int          frame_edges = 0;
  int          frame_len   = 0;
  int          bit_n       = 0;
  int          words_rx    = 0;
  int          done_cnt    = 0;
  logic [15:0] shreg       = '0;

  always @(negedge clk) begin
    if (reset) begin
      sclk_prev   = 1'b0;
      frame_edges = 0;
      frame_len   = 0;
      bit_n       = 0;
      words_rx    = 0;
    end else begin
      if (bus.frameOut) frame_len++;
      if (bus.serialClockOut && !sclk_prev) begin
        edges_total++;
        frame_edges++;
        shreg = {shreg[14:0], bus.serialDataOut};
        bit_n++;
        if (bit_n == 16) begin
          bit_n = 0;
          if (exp_q.size() == 0) check_eq("sb_empty", 32'(exp_q.size()), 32'd1);
          else check_eq($sformatf("word%0d", words_rx), 32'(shreg), 32'(exp_q.pop_front()));
          words_rx++;
        end
      end
      if (bus.txDone) begin
        done_cnt++;
        check_eq("frame_edges", 32'(frame_edges), 32'(FrameBits));
        check_eq("frame_len", 32'(frame_len), 32'(FrameCycles));
        check_eq("bit_align", 32'(bit_n), 32'd0);
        frame_edges = 0;
        frame_len   = 0;
        words_rx    = 0;
      end
      sclk_prev = bus.serialClockOut;
    end
  end

  task automatic set_pattern(input logic [3:0] mi, input logic [15:0] base, input logic [15:0] step);
    bus.maxIndex = mi;
    for (int i = 0; i < numOutputs; i++) bus.NNout[i*16 +: 16] = base + step * 16'(i);
  endtask

  task automatic push_frame();
    exp_q.push_back({8'hA5, 4'h0, bus.maxIndex});
    for (int i = 0; i < numOutputs; i++) exp_q.push_back(bus.NNout[i*16 +: 16]);
  endtask

  task automatic accept();
    @(negedge clk);
    check_eq("ready_before_accept", 32'(bus.ready), 32'd1);
    push_frame();
    bus.resultValid = 1'b1;
    @(negedge clk);
    bus.resultValid = 1'b0;
    check_eq("frame_after_accept", 32'(bus.frameOut), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.txDone) seen = 1'b1;
    end
    if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit reached;
    reset           = 1'b1;
    bus.resultValid = 1'b0;
    bus.NNout       = '0;
    bus.maxIndex    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(bus.ready), 32'd1);
    check_eq("rst_frame", 32'(bus.frameOut), 32'd0);
    check_eq("rst_sclk", 32'(bus.serialClockOut), 32'd0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b0;

    // Idle: nothing moves for 100 cycles.
    repeat (100) @(negedge clk);
    check_eq("idle_edges", 32'(edges_total), 32'd0);
    check_eq("idle_frame", 32'(bus.frameOut), 32'd0);
    check_eq("idle_txdone_cnt", 32'(done_cnt), 32'd0);

    // Frame A: maxIndex 7, NNout[i] = 0x0101*i.
    set_pattern(4'd7, 16'h0000, 16'h0101);
    accept();
    wait_done(2000);
    @(negedge clk);
    check_eq("a_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("a_ready", 32'(bus.ready), 32'd1);
    check_eq("a_sb_empty", 32'(exp_q.size()), 32'd0);

    // Frame B: busy offer sets overrun; inputs change mid-frame without effect.
    set_pattern(4'd3, 16'h1234, 16'h1111);
    accept();
    repeat (200) @(negedge clk);
    set_pattern(4'd9, 16'hBEEF, 16'h0F0F);
    bus.resultValid = 1'b1;
    @(negedge clk);
    bus.resultValid = 1'b0;
    check_eq("overrun_set", 32'(bus.overrun), 32'd1);
    repeat (50) @(negedge clk);
    set_pattern(4'd1, 16'hFFFF, 16'hFFFF);
    wait_done(2000);
    check_eq("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Frame C clears overrun on accept.
    set_pattern(4'd12, 16'h8001, 16'h0302);
    accept();
    check_eq("overrun_cleared", 32'(bus.overrun), 32'd0);
    wait_done(2000);

    // Frame D aborted by reset during word 4.
    set_pattern(4'd5, 16'h5A5A, 16'h0011);
    accept();
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clk);
      if (words_rx == 4 && bit_n == 5) reached = 1'b1;
    end
    check_eq("reach_word4", 32'(reached), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_ready", 32'(bus.ready), 32'd1);
    check_eq("abort_frame", 32'(bus.frameOut), 32'd0);
    check_eq("abort_sclk", 32'(bus.serialClockOut), 32'd0);
    check_eq("abort_sdo", 32'(bus.serialDataOut), 32'd0);
    check_eq("abort_txdone", 32'(bus.txDone), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check_eq("abort_no_done", 32'(done_cnt), 32'd3);

    // Frame E after reset must start from the header.
    set_pattern(4'd2, 16'h0A0B, 16'h0102);
    accept();
    wait_done(2000);
    check_eq("e_sb_empty", 32'(exp_q.size()), 32'd0);

    // resultValid held: two frames, exactly one idle cycle between.
    repeat (5) @(negedge clk);
    set_pattern(4'd15, 16'hC000, 16'h0203);
    push_frame();
    bus.resultValid = 1'b1;
    wait_done(2000);
    push_frame();
    @(negedge clk);
    check_eq("gap_idle_frame", 32'(bus.frameOut), 32'd0);
    check_eq("gap_idle_ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    check_eq("gap_rise", 32'(bus.frameOut), 32'd1);
    bus.resultValid = 1'b0;
    wait_done(2000);
    repeat (20) @(negedge clk);
    check_eq("held_no_third", 32'(bus.frameOut), 32'd0);
    check_eq("held_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("total_done", 32'(done_cnt), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nn_result_serializer.md
Name: nn_result_serializer

Overview:
- Transmit side of the Arduino serial link. Sends classification results from the FPGA back to the Arduino.
- Latches the NeuralNetwork output vector and maxIndex when a result is valid.
- Sends one framed burst of 16-bit words, MSB-first, on a generated serial clock. The receiver samples data on the rising clock edge, the same convention the input shift path uses.
- Sits beside the NeuralNetwork instance in top. Its pins go to spare ARDUINO_IO lines.

Parameters:
- dataWidth, 16, width of each transmitted word and of each NNout element
- numOutputs, 10, number of NNout elements sent after the header
- clkDiv, 25, clk cycles per serial-clock half period; 25 gives 1 MHz at 50 MHz; legal range 2 or more
- headerTag, 8'hA5, upper byte of the header word

Ports:
- clk  in  1  system clock (CLOCK_50 in top)
- reset  in  1  asynchronous, active-high
- NNout  in  numOutputs*dataWidth  network outputs; element i is NNout[i*dataWidth +: dataWidth]
- maxIndex  in  4  argmax class index
- resultValid  in  1  single-cycle or level strobe; a result is offered while high
- ready  out  1  high when idle and able to accept a result
- serialClockOut  out  1  generated serial clock; idles low
- serialDataOut  out  1  serial data, MSB-first
- frameOut  out  1  high for the entire frame, including lead and trail
- txDone  out  1  one-cycle pulse after the frame ends
- overrun  out  1  sticky flag: a result arrived while busy

Behaviour:
- Reset values (asynchronous, immediate):
  - ready=1; serialClockOut=0; serialDataOut=0; frameOut=0; txDone=0; overrun=0.
  - State=IDLE; all counters=0.
  - Reset mid-frame aborts the frame with no further edges.
- Accept: in IDLE, resultValid=1 on a clk edge causes the following on that edge:
  - Capture the frame. Word 0 = {headerTag, 4'h0, maxIndex}. Words 1..numOutputs = NNout element 0..numOutputs-1.
  - ready goes low. Go to LEAD.
- Busy offers: resultValid while not in IDLE is ignored; overrun is set. overrun clears on the next accepted result.
- States:
  - IDLE.
  - LEAD: frameOut=1, serialClockOut=0, serialDataOut=MSB of word 0. Lasts clkDiv cycles, then go to SHIFT.
  - SHIFT: see bit timing below.
  - TRAIL: frameOut=1, serialClockOut=0. Lasts clkDiv cycles, then go to DONE.
  - DONE: one cycle; txDone=1, frameOut=0, serialDataOut=0. Then go to IDLE with ready=1.
- Bit timing in SHIFT:
  - Each bit lasts 2*clkDiv clk cycles: low half, then high half.
  - serialDataOut changes only at the start of a low half, so it is stable for clkDiv cycles before each rising edge.
  - Counters: divCnt 0..clkDiv-1, bitCnt dataWidth-1 down to 0, wordCnt 0..numOutputs. All wrap cleanly.
  - After the high half of bit 0 of word numOutputs, go to TRAIL.
- Frame totals:
  - Bits = (numOutputs+1)*dataWidth = 176 by default.
  - Rising edges = 176.
  - Frame length = clkDiv*(2 + 2*176) cycles.
  - The next accept is possible on the cycle after txDone.
- Data integrity: the frame is sent from the captured copy. Changes on NNout or maxIndex during a frame have no effect.
- resultValid held high continuously: one frame per accept. Back-to-back frames are separated by exactly one IDLE cycle.

Decomposition:
- Package nn_link_pkg holds:
  - dataWidth, numOutputs, headerTag, and a frameWords constant (numOutputs+1).
  - The state enum {IDLE, LEAD, SHIFT, TRAIL, DONE}.
- The same package is used by the input shift register.
- One sub-module: serial_tick_gen. It counts clkDiv, emits a halfTick pulse, and holds a phase bit for serialClockOut. It is cleared whenever the FSM is in IDLE.

Test Plan (clkDiv=2 for simulation):
- Reset then idle -> ready=1, frameOut=0, serialClockOut=0, no edges for 100 cycles.
- Accept with maxIndex=7 and NNout[i]=16'h0100*i+i -> exactly 176 rising edges. The bits sampled at rising edges reassemble to 16'hA507, then 16'h0000, 16'h0101, … 16'h0909. frameOut is high for 2*(2+352)=708 cycles. txDone pulses once.
- resultValid pulsed mid-frame -> overrun=1, and the frame content is unchanged. The next accept clears overrun.
- Change NNout during transmission -> the transmitted words equal the values captured at accept.
- Assert reset in the middle of word 4 -> all outputs go to their reset values in the same cycle. A new accept after reset starts from the header.
- resultValid held high -> two consecutive frames. The gap is exactly one IDLE cycle between txDone and the next frameOut rise.
